// File: rtl/team_06_audio_gain_gate.sv
`default_nettype none
// ============================================================================
//  Module   : team_06_audio_gain_gate
//  Purpose  : Microphone sample conditioning. A noise gate with a hold timer,
//             then mute / push-to-talk gating, then volume/8 gain with
//             saturation. Fixed 2-cycle pipeline, one sample per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module team_06_audio_gain_gate #(
   parameter logic [7:0]  THRESH       = 8'd12,
   parameter logic [15:0] HOLD_SAMPLES = 16'd800,
   parameter logic        PTT_REQUIRED = 1'b1
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   input  logic [3:0] volume,
   input  logic       ptt,
   input  logic       noise_gate,
   input  logic       mute,
   output logic [7:0] sample_out,
   output logic       out_valid,
   output logic       gate_open
);

   typedef enum logic [1:0] {
      ST_CLOSED = 2'd0,
      ST_OPEN   = 2'd1,
      ST_HOLD   = 2'd2
   } gate_state_t;

   gate_state_t state, state_nxt;
   logic [15:0] hold_cnt, hold_cnt_nxt, hold_cnt_inc;
   logic [7:0]  mag;
   logic        loud;
   logic        pass1_nxt;

   logic        s1_valid;
   logic [7:0]  s1_sample;
   logic        s1_pass;

   logic signed [11:0] prod;
   logic signed [11:0] scaled;
   logic [7:0]         sat;
   logic               pass;

   // |sample|, with -128 clamped to 127 so it fits the unsigned 7-bit range
   always_comb begin
      mag = sample_in;
      if (sample_in == 8'h80)
         mag = 8'd127;
      else if (sample_in[7])
         mag = ~sample_in + 8'd1;
   end

   assign loud         = (mag >= THRESH);
   assign hold_cnt_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;

   // Gate state and below-threshold counter registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= ST_CLOSED;
         hold_cnt <= 16'd0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Gate next state; only valid samples move the FSM. A HOLD_SAMPLES of 0
   // is treated like 1 (close on the first quiet sample).
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      if (sample_valid) begin
         if (!noise_gate) begin
            state_nxt    = ST_OPEN;
            hold_cnt_nxt = 16'd0;
         end else begin
            case (state)
               ST_CLOSED: begin
                  if (loud) begin
                     state_nxt    = ST_OPEN;
                     hold_cnt_nxt = 16'd0;
                  end
               end
               ST_OPEN: begin
                  if (!loud) begin
                     hold_cnt_nxt = 16'd1;
                     state_nxt    = (HOLD_SAMPLES <= 16'd1) ? ST_CLOSED : ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (loud) begin
                     state_nxt    = ST_OPEN;
                     hold_cnt_nxt = 16'd0;
                  end else begin
                     hold_cnt_nxt = hold_cnt_inc;
                     state_nxt    = (hold_cnt_inc >= HOLD_SAMPLES) ? ST_CLOSED : ST_HOLD;
                  end
               end
               default: begin
                  state_nxt    = ST_CLOSED;
                  hold_cnt_nxt = 16'd0;
               end
            endcase
         end
      end
   end

   assign pass1_nxt = (state_nxt != ST_CLOSED);
   assign gate_open = (state != ST_CLOSED);

   // Stage 1: capture the sample together with the gate decision
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s1_valid  <= 1'b0;
         s1_sample <= 8'd0;
         s1_pass   <= 1'b0;
      end else begin
         s1_valid <= sample_valid;
         if (sample_valid) begin
            s1_sample <= sample_in;
            s1_pass   <= pass1_nxt;
         end
      end
   end

   // Stage 2 gain: sample * volume / 8, floor division, clamped to 8 bits
   assign prod   = $signed({{4{s1_sample[7]}}, s1_sample}) * $signed({8'd0, volume});
   assign scaled = prod >>> 3;
   assign pass   = s1_pass & ~mute & (ptt | ~PTT_REQUIRED);

   // Saturate the scaled product to [-128, 127]
   always_comb begin
      sat = scaled[7:0];
      if (scaled > 12'sd127)
         sat = 8'h7F;
      else if (scaled < -12'sd128)
         sat = 8'h80;
   end

   // Stage 2: output register; sample_out holds between valid strobes
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_valid  <= 1'b0;
         sample_out <= 8'd0;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid)
            sample_out <= pass ? sat : 8'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_team_06_audio_gain_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_team_06_audio_gain_gate
//  Purpose  : Directed self-checking bench for team_06_audio_gain_gate
//  Revision : 1.0 - initial release
// ============================================================================
module tb_team_06_audio_gain_gate;

   logic       clk;
   logic       nrst;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic [3:0] volume;
   logic       ptt;
   logic       noise_gate;
   logic       mute;
   logic [7:0] sample_out;
   logic       out_valid;
   logic       gate_open;

   int checks = 0;
   int errors = 0;

   team_06_audio_gain_gate #(
      .THRESH       (8'd12),
      .HOLD_SAMPLES (16'd3),
      .PTT_REQUIRED (1'b1)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .volume       (volume),
      .ptt          (ptt),
      .noise_gate   (noise_gate),
      .mute         (mute),
      .sample_out   (sample_out),
      .out_valid    (out_valid),
      .gate_open    (gate_open)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int out_s();
      return int'($signed(sample_out));
   endfunction

   // One isolated sample: quiet at N+1, strobe with value at N+2, quiet at N+3
   task automatic send1(input int x, input int expected, input string tag);
      sample_in    = x[7:0];
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      chk({tag, "_lat1"}, int'(out_valid), 0);
      step();
      chk({tag, "_vld"}, int'(out_valid), 1);
      chk(tag, out_s(), expected);
      step();
      chk({tag, "_one"}, int'(out_valid), 0);
   endtask

   task automatic do_reset();
      nrst         = 1'b0;
      sample_valid = 1'b0;
      step();
      step();
      nrst = 1'b1;
      step();
   endtask

   initial begin
      nrst         = 1'b0;
      sample_in    = 8'd50;
      sample_valid = 1'b1;
      volume       = 4'd8;
      ptt          = 1'b1;
      noise_gate   = 1'b0;
      mute         = 1'b0;

      // Reset held while valid samples are driven
      step();
      step();
      step();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_sample_out", out_s(), 0);
      chk("rst_gate_open", int'(gate_open), 0);
      nrst         = 1'b1;
      sample_valid = 1'b0;
      step();
      chk("post_rst_idle", int'(out_valid), 0);
      send1(9, 9, "first_out");

      // Unity gain, back-to-back samples
      sample_in = 8'd5; sample_valid = 1'b1;
      step();
      sample_in = 8'hF9;
      chk("b2b_lat1", int'(out_valid), 0);
      step();
      chk("b2b0_vld", int'(out_valid), 1);
      chk("b2b0", out_s(), 5);
      sample_in = 8'd100;
      step();
      sample_valid = 1'b0;
      chk("b2b1_vld", int'(out_valid), 1);
      chk("b2b1", out_s(), -7);
      step();
      chk("b2b2_vld", int'(out_valid), 1);
      chk("b2b2", out_s(), 100);
      step();
      chk("b2b_end", int'(out_valid), 0);
      chk("b2b_hold", out_s(), 100);

      // Saturation and rounding
      volume = 4'd15;
      send1(127, 127, "v15_pos_sat");
      send1(-128, -128, "v15_neg_sat");
      send1(16, 30, "v15_16");
      volume = 4'd1;
      send1(-1, -1, "v1_floor_neg");
      send1(7, 0, "v1_floor_pos");
      volume = 4'd0;
      send1(50, 0, "v0");
      volume = 4'd8;

      // Noise gate with hold timer (THRESH=12, HOLD_SAMPLES=3)
      do_reset();
      noise_gate = 1'b1;
      send1(3, 0, "gate_closed_blk");
      chk("gate_closed_state", int'(gate_open), 0);
      send1(20, 20, "gate_open_pass");
      chk("gate_open_state", int'(gate_open), 1);
      send1(2, 2, "gate_hold1");
      chk("gate_hold1_state", int'(gate_open), 1);
      send1(2, 2, "gate_hold2");
      send1(2, 0, "gate_close_blk");
      chk("gate_close_state", int'(gate_open), 0);
      send1(-12, -12, "gate_reopen_thr");
      chk("gate_reopen_state", int'(gate_open), 1);

      // PTT and mute gating
      ptt = 1'b0;
      send1(40, 0, "ptt_low");
      ptt  = 1'b1;
      mute = 1'b1;
      send1(40, 0, "mute_on");
      // mute drops between stage 1 and stage 2: the sample passes
      sample_in = 8'd33; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      mute         = 1'b0;
      step();
      chk("mute_fall_vld", int'(out_valid), 1);
      chk("mute_fall", out_s(), 33);
      step();
      // mute rises in stage 2: the sample is blocked
      sample_in = 8'd34; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      mute         = 1'b1;
      step();
      chk("mute_rise_vld", int'(out_valid), 1);
      chk("mute_rise", out_s(), 0);
      step();
      mute = 1'b0;

      // Reset while samples are in flight
      noise_gate = 1'b0;
      sample_in = 8'd60; sample_valid = 1'b1;
      step();
      sample_in = 8'd61;
      #18;
      nrst         = 1'b0;
      sample_valid = 1'b0;
      step();
      chk("mid_rst_vld", int'(out_valid), 0);
      chk("mid_rst_gate", int'(gate_open), 0);
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_rst_dropped", int'(out_valid), 0);
      end
      noise_gate = 1'b1;
      send1(3, 0, "closed_after_rst");
      chk("closed_after_rst_state", int'(gate_open), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
